// File: rtl/ring_phase_monitor.sv
// Watches a one-hot 8-phase ring counter, tracks its phase and flags illegal or out-of-order samples.
// Optional revolution counter is built only when RING_MONITOR_REV_COUNT_EN is defined.
module ring_phase_monitor #(
  parameter int unsigned REV_W = 8
) (
  input  logic             clock,
  input  logic             init,
  input  logic [0:7]       ring_in,
  input  logic             clr_err,
  output logic [2:0]       phase,
  output logic             phase_valid,
  output logic [REV_W-1:0] rev_count,
  output logic             err_illegal,
  output logic             err_skip,
  output logic             err_sticky,
  output logic             reinit_req
);

  typedef enum logic [1:0] {IDLE, TRACK, FAULT} state_t;

  state_t     state, state_nx;
  logic [2:0] phase_nx;
  logic       valid_nx, ill_nx, skip_nx, sticky_nx, reinit_nx;
  logic [3:0] hot_cnt;
  logic [2:0] hot_idx;
  logic       legal;

  always_comb begin
    hot_cnt = '0;
    hot_idx = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (ring_in[i]) begin
        hot_cnt = hot_cnt + 4'd1;
        hot_idx = 3'(i);
      end
    end
    legal = (hot_cnt == 4'd1);
  end

  // Any error overrides a coincident clr_err because it re-sets sticky after the default clear.
  always_comb begin
    state_nx  = state;
    phase_nx  = phase;
    valid_nx  = phase_valid;
    ill_nx    = 1'b0;
    skip_nx   = 1'b0;
    sticky_nx = clr_err ? 1'b0 : err_sticky;
    reinit_nx = reinit_req;
    case (state)
      IDLE: begin
        if (legal) begin
          phase_nx = hot_idx;
          valid_nx = 1'b1;
          state_nx = TRACK;
        end else begin
          ill_nx    = 1'b1;
          valid_nx  = 1'b0;
          sticky_nx = 1'b1;
          reinit_nx = 1'b1;
          state_nx  = FAULT;
        end
      end
      TRACK: begin
        if (!legal || (hot_idx != phase + 3'd1)) begin
          ill_nx    = !legal;
          skip_nx   = legal;
          valid_nx  = 1'b0;
          sticky_nx = 1'b1;
          reinit_nx = 1'b1;
          state_nx  = FAULT;
        end else begin
          phase_nx = hot_idx;
        end
      end
      FAULT: begin
        valid_nx  = 1'b0;
        reinit_nx = 1'b1;
        if (clr_err) begin
          sticky_nx = 1'b0;
          reinit_nx = 1'b0;
          state_nx  = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (init) begin
      state       <= IDLE;
      phase       <= '0;
      phase_valid <= 1'b0;
      err_illegal <= 1'b0;
      err_skip    <= 1'b0;
      err_sticky  <= 1'b0;
      reinit_req  <= 1'b0;
    end else begin
      state       <= state_nx;
      phase       <= phase_nx;
      phase_valid <= valid_nx;
      err_illegal <= ill_nx;
      err_skip    <= skip_nx;
      err_sticky  <= sticky_nx;
      reinit_req  <= reinit_nx;
    end
  end

`ifdef RING_MONITOR_REV_COUNT_EN
  logic rev_step;
  assign rev_step = (state == TRACK) && legal && (phase == 3'd7) && (hot_idx == 3'd0);

  always_ff @(posedge clock) begin
    if (init)
      rev_count <= '0;
    else if (rev_step)
      rev_count <= rev_count + REV_W'(1);
  end
`else
  assign rev_count = '0;
`endif

endmodule

// File: tb/tb_ring_phase_monitor.sv
// Scoreboard bench for ring_phase_monitor: directed scenarios followed by randomized traffic.
module tb_ring_phase_monitor;
  localparam int unsigned TB_REV_W = 2;

  logic                clock = 1'b0;
  logic                init;
  logic [0:7]          ring_in;
  logic                clr_err;
  logic [2:0]          phase;
  logic                phase_valid;
  logic [TB_REV_W-1:0] rev_count;
  logic                err_illegal, err_skip, err_sticky, reinit_req;

  ring_phase_monitor #(.REV_W(TB_REV_W)) dut (
    .clock(clock), .init(init), .ring_in(ring_in), .clr_err(clr_err),
    .phase(phase), .phase_valid(phase_valid), .rev_count(rev_count),
    .err_illegal(err_illegal), .err_skip(err_skip), .err_sticky(err_sticky),
    .reinit_req(reinit_req)
  );

  always #5 clock = ~clock;

  typedef struct {
    int phase, valid, rev, ill, skip, sticky, reinit;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  // Reference model: behaviour expressed as flags and integers
  bit m_track, m_fault;
  int m_phase, m_revs;
  bit m_valid, m_ill, m_skip, m_sticky, m_reinit;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d time=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [0:7] to_ring(input int idx);
    logic [0:7] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  function automatic logic [0:7] next_ring();
    return to_ring(m_track ? (m_phase + 1) % 8 : 0);
  endfunction

  task automatic go_fault(input bit illegal);
    m_ill    = illegal;
    m_skip   = !illegal;
    m_fault  = 1;
    m_track  = 0;
    m_valid  = 0;
    m_sticky = 1;
    m_reinit = 1;
  endtask

  task automatic model_step(input bit i, input logic [0:7] r, input bit c);
    int n, idx;
    m_ill  = 0;
    m_skip = 0;
    if (i) begin
      m_track = 0; m_fault = 0; m_phase = 0; m_revs = 0;
      m_valid = 0; m_sticky = 0; m_reinit = 0;
      return;
    end
    if (m_fault) begin
      if (c) begin
        m_fault = 0; m_sticky = 0; m_reinit = 0;
      end
      return;
    end
    n = $countones(r);
    idx = 0;
    for (int k = 0; k < 8; k++) if (r[k]) idx = k;
    if (n != 1) go_fault(1);
    else if (!m_track) begin
      m_phase = idx; m_valid = 1; m_track = 1;
      if (c) m_sticky = 0;
    end else if (idx == (m_phase + 1) % 8) begin
      if (m_phase == 7) m_revs++;
      m_phase = idx;
      if (c) m_sticky = 0;
    end else go_fault(0);
  endtask

  task automatic drive(input bit i, input logic [0:7] r, input bit c);
    exp_t e;
    @(negedge clock);
    init = i; ring_in = r; clr_err = c;
    model_step(i, r, c);
    e.phase = m_phase; e.valid = m_valid;
`ifdef RING_MONITOR_REV_COUNT_EN
    e.rev = m_revs % (1 << TB_REV_W);
`else
    e.rev = 0;
`endif
    e.ill = m_ill; e.skip = m_skip; e.sticky = m_sticky; e.reinit = m_reinit;
    sb.push_back(e);
  endtask

  task automatic rotate_to(input int p);
    for (int n = 0; n < 16 && !(m_track && m_phase == p); n++) drive(0, next_ring(), 0);
  endtask

  // Monitor: the DUT presents a registered response every cycle
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("phase", int'(phase), e.phase);
        check("phase_valid", int'(phase_valid), e.valid);
        check("rev_count", int'(rev_count), e.rev);
        check("err_illegal", int'(err_illegal), e.ill);
        check("err_skip", int'(err_skip), e.skip);
        check("err_sticky", int'(err_sticky), e.sticky);
        check("reinit_req", int'(reinit_req), e.reinit);
        if (err_illegal && err_skip) check("err_exclusive", 1, 0);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int r;
    init = 1'b1; ring_in = '0; clr_err = 1'b0;

    drive(1, 8'h5A, 0);
    drive(1, 8'h00, 0);
    for (int k = 0; k < 20; k++) drive(0, to_ring(k % 8), 0);

    rotate_to(3);
    drive(0, 8'b00000000, 0);
    drive(0, next_ring(), 0);
    drive(0, 8'b00000000, 1);
    drive(0, 8'b10000000, 0);

    rotate_to(2);
    drive(0, 8'b00001000, 0);
    drive(0, 8'b00000100, 0);
    drive(0, 8'b00000100, 0);
    drive(0, 8'b11000000, 1);
    drive(0, 8'b10000000, 0);

    rotate_to(5);
    drive(0, 8'b11111111, 1);
    drive(0, 8'b00000001, 0);
    drive(0, 8'b00000000, 1);

    drive(1, 8'h00, 0);
    for (int k = 0; k < 41; k++) drive(0, to_ring(k % 8), 0);
    drive(0, to_ring(1), 0);
    drive(0, to_ring(1), 1);
    drive(0, to_ring(0), 0);
    rotate_to(4);
    drive(1, to_ring(5), 1);
    drive(0, to_ring(6), 0);

    for (int k = 0; k < 500; k++) begin
      r = $urandom_range(0, 31);
      if (r == 0) drive(1, 8'($urandom), 0);
      else if (m_fault) drive(0, 8'($urandom), ($urandom_range(0, 3) == 0));
      else if (r < 3) drive(0, 8'($urandom), $urandom_range(0, 1));
      else if (r < 5) drive(0, to_ring($urandom_range(0, 7)), $urandom_range(0, 1));
      else drive(0, next_ring(), (r == 5));
    end

    for (int n = 0; n < 4 && sb.size() > 0; n++) @(posedge clock);
    #2;
    if (sb.size() != 0) check("scoreboard_drain", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ring_phase_monitor.md
RING_PHASE_MONITOR -- requirements
Module: ring_phase_monitor

Interface
REQ-001 Parameter REV_W, default 8, width of the revolution counter.
REQ-002 clock  input  1  single clock; all state updates on posedge clock.
REQ-003 init  input  1  reset, synchronous, active-high; shared with the upstream 8-bit ring counter.
REQ-004 ring_in  input  [0:7]  one-hot phase from the upstream ring counter; ring_in[0] is phase 0 (value 8'b10000000 after init); the hot bit advances toward ring_in[7], then wraps to ring_in[0].
REQ-005 clr_err  input  1  single-cycle request to clear the fault condition.
REQ-006 phase  output  3  binary index of the hot bit of the last legal sample.
REQ-007 phase_valid  output  1  high while the monitor is tracking a legal rotation.
REQ-008 rev_count  output  REV_W  count of completed revolutions (phase 7 -> 0 transitions).
REQ-009 err_illegal  output  1  one-cycle pulse; sample was zero-hot or multi-hot.
REQ-010 err_skip  output  1  one-cycle pulse; legal sample did not equal the previous phase +1 mod 8.
REQ-011 err_sticky  output  1  set by any error; held until cleared.
REQ-012 reinit_req  output  1  level; asks the system to pulse init on the ring counter.

Function
REQ-013 All outputs SHALL be registered; each response appears 1 cycle after the ring_in sample that causes it.
REQ-014 FSM states SHALL be IDLE, TRACK and FAULT.
REQ-015 IDLE: a legal one-hot sample SHALL load phase, assert phase_valid and go to TRACK, with no rotation check; an illegal sample SHALL pulse err_illegal and go to FAULT.
REQ-016 TRACK: a legal sample with index == (phase+1) mod 8 SHALL update phase and stay in TRACK.
REQ-017 TRACK: a zero-hot or multi-hot sample SHALL pulse err_illegal, clear phase_valid, hold phase and go to FAULT.
REQ-018 TRACK: a legal sample with a wrong index, including an unchanged index (stall), SHALL pulse err_skip, clear phase_valid, hold phase and go to FAULT.
REQ-019 err_illegal and err_skip SHALL never be asserted in the same cycle; illegal takes priority.
REQ-020 rev_count SHALL increment by 1 on each legal 7 -> 0 step in TRACK only; it wraps from 2^REV_W-1 to 0 and holds its value in FAULT.
REQ-021 FAULT: reinit_req SHALL be high and phase_valid low; further samples SHALL be ignored, with no new error pulses.
REQ-022 clr_err in FAULT SHALL clear err_sticky and reinit_req and go to IDLE on the next cycle.
REQ-023 clr_err in IDLE or TRACK SHALL clear err_sticky only.
REQ-024 If an error and clr_err occur in the same cycle, the error SHALL win: err_sticky stays set and the state goes to or stays in FAULT.

Reset
REQ-025 While init is high at a posedge: state = IDLE, phase = 0, phase_valid = 0, rev_count = 0, err_illegal = 0, err_skip = 0, err_sticky = 0, reinit_req = 0; ring_in is not evaluated.
REQ-026 init asserted in any state, including mid-rotation or FAULT, SHALL take priority over all other inputs.
REQ-027 The first sample after init deasserts (8'b10000000) SHALL be accepted in IDLE as phase 0.

Configuration
REQ-028 Macro RING_MONITOR_REV_COUNT_EN: when defined, rev_count behaves per REQ-020.
REQ-029 When RING_MONITOR_REV_COUNT_EN is not defined, no counter logic is built and rev_count is tied to 0; all other behaviour is unchanged.

Verification
REQ-030 init for 2 cycles, then a clean rotation for 20 cycles -> phase_valid high from cycle 1, phase follows 0,1,...,7,0,...; with the macro defined, rev_count = 2 after the second 7 -> 0 step; no error pulses.
REQ-031 During TRACK at phase 3, drive ring_in = 8'b00000000 -> err_illegal pulses for 1 cycle, err_sticky = 1, reinit_req = 1, phase holds 3.
REQ-032 At phase 2, drive ring_in = 8'b00001000 (index 4) -> err_skip pulses; then hold ring_in at index 5 for 2 cycles -> FAULT is held and no further pulses occur.
REQ-033 In FAULT, pulse clr_err and then present 8'b10000000 -> return to IDLE, then TRACK with phase 0; err_sticky = 0, reinit_req = 0.
REQ-034 Error sample coincident with clr_err in TRACK -> FAULT entered and err_sticky = 1; with REV_W = 2, 5 revolutions give rev_count = 1 (wrap); init asserted mid-rotation -> all outputs 0 on the next cycle.
